// File: rtl/parity_serial_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// parity_serial_rx
// Receiving end of the serial parity link. Deserialises one frame per
// transfer (start bit, DATA_W data bits LSB first, one parity bit, one stop
// bit), sampling sin only on cycles where bit_en is high. Parity is rebuilt
// with a running XOR and reported together with the stop-bit status.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   bit_en     bit-sample strobe
//   sin        serial data line, idle high
//   data_out   last received data word (holds until the next frame completes)
//   data_valid one-cycle pulse after the edge that samples the stop bit
//   parity_err parity mismatch of the last completed frame
//   frame_err  stop bit was 0 in the last completed frame
//   busy       high while a frame is in progress
// -----------------------------------------------------------------------------
module parity_serial_rx #(
    parameter int DATA_W     = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              sin,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic             ODD_BIT  = (ODD_PARITY != 0) ? 1'b1 : 1'b0;

    // Parity check: the XOR of all data bits and the parity bit must equal
    // the selected parity sense, otherwise the frame is flagged.
    function automatic logic parity_mismatch(input logic acc, input logic pbit);
        return acc ^ pbit ^ ODD_BIT;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [DATA_W-1:0] shreg_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              acc_r;
    logic              perr_r;
    logic              busy_nxt_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; nothing moves without a strobe.
    always_comb begin
        state_nxt_s = state_r;
        if (bit_en) begin
            case (state_r)
                IDLE: begin
                    if (!sin) begin
                        state_nxt_s = DATA;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                DATA: begin
                    if (cnt_r == CNT_LAST) begin
                        state_nxt_s = PARITY;
                    end else begin
                        state_nxt_s = DATA;
                    end
                end
                PARITY:  state_nxt_s = STOP;
                STOP:    state_nxt_s = IDLE;
                default: state_nxt_s = IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Output decode: busy follows the state being entered so the registered
    // copy is high exactly while the FSM is outside IDLE.
    always_comb begin
        busy_nxt_s = 1'b0;
        if (state_nxt_s != IDLE) begin
            busy_nxt_s = 1'b1;
        end else begin
            busy_nxt_s = 1'b0;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_r    <= '0;
            cnt_r      <= '0;
            acc_r      <= 1'b0;
            perr_r     <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            busy       <= busy_nxt_s;
            if (bit_en) begin
                case (state_r)
                    IDLE: begin
                        if (!sin) begin
                            shreg_r <= '0;
                            cnt_r   <= '0;
                            acc_r   <= 1'b0;
                        end
                    end
                    DATA: begin
                        // LSB arrives first, so shift in from the top.
                        shreg_r <= {sin, shreg_r[DATA_W-1:1]};
                        acc_r   <= acc_r ^ sin;
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                    PARITY: begin
                        perr_r <= parity_mismatch(acc_r, sin);
                    end
                    STOP: begin
                        // Errored frames are still delivered; flags qualify them.
                        data_out   <= shreg_r;
                        parity_err <= perr_r;
                        frame_err  <= ~sin;
                        data_valid <= 1'b1;
                    end
                    default: begin
                        perr_r <= perr_r;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_parity_serial_rx.sv
`timescale 1ns/1ps
// Bench for parity_serial_rx: one even-parity and one odd-parity instance
// receive the same serial stream; every delivered frame is compared against
// expectations computed from the frame contents by a queue-based model.
module tb_parity_serial_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_en;
    logic       sin;
    logic [7:0] dout_e, dout_o;
    logic       dv_e, dv_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int dv_count = 0;
    int dv_last_cyc = 0;
    int dv_prev_cyc = 0;
    int frames_sent = 0;

    typedef struct {
        logic [7:0] d;
        logic       pe_even;
        logic       pe_odd;
        logic       fe;
    } exp_t;
    exp_t expq[$];

    parity_serial_rx #(.DATA_W(8), .ODD_PARITY(0)) u_even (
        .clk(clk), .rst(rst), .bit_en(bit_en), .sin(sin),
        .data_out(dout_e), .data_valid(dv_e), .parity_err(pe_e),
        .frame_err(fe_e), .busy(busy_e)
    );

    parity_serial_rx #(.DATA_W(8), .ODD_PARITY(1)) u_odd (
        .clk(clk), .rst(rst), .bit_en(bit_en), .sin(sin),
        .data_out(dout_o), .data_valid(dv_o), .parity_err(pe_o),
        .frame_err(fe_o), .busy(busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Monitor: score every completed frame on the falling edge.
    always @(negedge clk) begin
        if (dv_e || dv_o) begin
            check_eq("dv_match", dv_o, dv_e);
        end
        if (dv_e) begin
            exp_t e;
            dv_count++;
            dv_prev_cyc = dv_last_cyc;
            dv_last_cyc = cyc;
            if (expq.size() == 0) begin
                check_eq("unexpected_dv", 1, 0);
            end else begin
                e = expq.pop_front();
                check_eq("data_even", dout_e, e.d);
                check_eq("data_odd", dout_o, e.d);
                check_eq("perr_even", pe_e, e.pe_even);
                check_eq("perr_odd", pe_o, e.pe_odd);
                check_eq("ferr_even", fe_e, e.fe);
                check_eq("ferr_odd", fe_o, e.fe);
            end
        end
    end

    // One strobed bit, preceded by gap idle cycles with random line noise.
    task automatic drive_bit(input logic b, input int gap);
        for (int i = 0; i < gap; i++) begin
            bit_en = 1'b0;
            sin    = 1'($urandom);
            @(posedge clk); #1;
        end
        bit_en = 1'b1;
        sin    = b;
        @(posedge clk); #1;
        bit_en = 1'b0;
        sin    = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop, input int gap);
        exp_t e;
        int   ones;
        drive_bit(1'b0, gap);
        check_eq("busy_after_start", busy_e, 1);
        for (int i = 0; i < 8; i++) drive_bit(d[i], gap);
        drive_bit(pbit, gap - 1 < 0 ? 0 : gap);
        ones      = $countones(d) + int'(pbit);
        e.d       = d;
        e.pe_even = (ones % 2) != 0;
        e.pe_odd  = (ones % 2) == 0;
        e.fe      = (stop == 1'b0);
        expq.push_back(e);
        frames_sent++;
        drive_bit(stop, gap);
        check_eq("busy_after_stop", busy_e, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        rst = 1'b1; bit_en = 1'b0; sin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_data", dout_e, 0);
        check_eq("rst_dv", dv_e, 0);
        check_eq("rst_perr", pe_e, 0);
        check_eq("rst_ferr", fe_e, 0);
        check_eq("rst_busy", busy_e, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Good even frame, strobe every cycle.
        base = dv_count;
        send_frame(8'hA5, 1'b0, 1'b1, 0);
        repeat (2) @(posedge clk); #1;
        check_eq("a5_pulses", dv_count - base, 1);
        check_eq("a5_hold", dout_e, 8'hA5);

        // Parity error.
        send_frame(8'h01, 1'b0, 1'b1, 0);
        // Framing error, then a high strobe must not start a frame.
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        drive_bit(1'b1, 0);
        check_eq("idle_after_ferr", busy_e, 0);

        // Strobe every 4th cycle with line noise between strobes.
        repeat (2) @(posedge clk); #1;
        base = dv_count;
        send_frame(8'hC3, 1'b0, 1'b1, 3);
        repeat (2) @(posedge clk); #1;
        check_eq("c3_pulses", dv_count - base, 1);

        // Abort mid-frame with reset.
        base = dv_count;
        drive_bit(1'b0, 0);
        drive_bit(1'b1, 0);
        drive_bit(1'b0, 0);
        drive_bit(1'b1, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("abort_data", dout_e, 0);
        check_eq("abort_perr", pe_e, 0);
        check_eq("abort_ferr", fe_e, 0);
        check_eq("abort_busy", busy_e, 0);
        repeat (3) @(posedge clk); #1;
        check_eq("abort_no_dv", dv_count - base, 0);
        send_frame(8'h7E, 1'b0, 1'b1, 1);

        // Back-to-back frames, odd-parity-correct on u_odd.
        repeat (2) @(posedge clk); #1;
        send_frame(8'hFF, 1'b1, 1'b1, 0);
        send_frame(8'h00, 1'b1, 1'b1, 0);
        repeat (2) @(posedge clk); #1;
        check_eq("b2b_spacing", dv_last_cyc - dv_prev_cyc, 11);

        // Random frames with random gaps, parity and stop bits.
        for (int k = 0; k < 24; k++) begin
            send_frame(8'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                       int'($urandom_range(0, 2)));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (4) @(posedge clk); #1;
        check_eq("pending_frames", expq.size(), 0);
        check_eq("total_pulses", dv_count, frames_sent);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
